// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter and sequencer for the shared 2:1 datapath mux.
// Two requesters stream multi-beat bursts into one registered output stage with a
// valid/ready handshake. A burst-length cap bounds how long one requester can hold
// the grant while the other is waiting.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; arbitrate between pending requests (1-cycle bubble)
// GNT0  | requester 0 owns the mux, beats from din_0 are accepted
// GNT1  | requester 1 owns the mux, beats from din_1 are accepted
module mux2_arbiter #(
    parameter int data_size = 32,
    parameter int max_burst = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_0,
    input  logic [data_size-1:0] din_0,
    input  logic                 last_0,
    output logic                 ack_0,
    input  logic                 req_1,
    input  logic [data_size-1:0] din_1,
    input  logic                 last_1,
    output logic                 ack_1,
    output logic                 sel,
    output logic [data_size-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Five bits cover the full legal cap range (1..16) plus one for the compare.
    localparam int cnt_w = 5;
    localparam logic [cnt_w-1:0] burst_cap = cnt_w'(max_burst);

    state_t               state;
    logic                 prio;
    logic [cnt_w-1:0]     beat_cnt;
    logic [cnt_w-1:0]     beat_nxt;

    logic                 load_en;
    logic                 accept;
    logic                 req_cur;
    logic                 req_oth;
    logic                 last_cur;
    logic                 oth_id;
    logic [data_size-1:0] din_cur;
    logic                 cap_hit;
    logic                 rel_grant;

    // The output stage can take a new word when empty or being drained this cycle.
    assign load_en = !dout_valid || dout_ready;

    assign ack_0  = (state == GNT0) && req_0 && load_en;
    assign ack_1  = (state == GNT1) && req_1 && load_en;
    assign accept = ack_0 || ack_1;

    assign sel  = (state == GNT1);
    assign busy = (state != IDLE);

    // Route the owner's and the other requester's signals by current grant.
    always_comb begin
        req_cur  = req_0;
        req_oth  = req_1;
        last_cur = last_0;
        din_cur  = din_0;
        oth_id   = 1'b1;
        if (state == GNT1) begin
            req_cur  = req_1;
            req_oth  = req_0;
            last_cur = last_1;
            din_cur  = din_1;
            oth_id   = 1'b0;
        end
    end

    assign beat_nxt = beat_cnt + 1'b1;

    // '>=' so a cap reached earlier without contention still fires once the
    // other requester shows up (beat_cnt is saturated at the cap by then).
    assign cap_hit   = accept && req_oth && (beat_nxt >= burst_cap);
    assign rel_grant = (state != IDLE) &&
                       (!req_cur || (accept && last_cur) || cap_hit);

    // Output register: load on an accepted beat, otherwise drain on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (accept) begin
            dout       <= din_cur;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Grant FSM: arbitration in IDLE, burst counting and release in GNTx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= '0;
            owner    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_0 && (!req_1 || !prio)) begin
                        state    <= GNT0;
                        owner    <= 1'b0;
                        beat_cnt <= '0;
                    end else if (req_1) begin
                        state    <= GNT1;
                        owner    <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (rel_grant) begin
                        prio <= oth_id;
                        if (req_oth) begin
                            // Hand over directly, no arbitration bubble.
                            state    <= oth_id ? GNT1 : GNT0;
                            owner    <= oth_id;
                            beat_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept && (beat_cnt != burst_cap)) begin
                        beat_cnt <= beat_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed bursts are queued per requester,
// expected output words are queued in hand-computed order, and a monitor pops
// and compares each word as the consumer takes it.
module tb_mux2_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_0 = 1'b0, last_0 = 1'b0, req_1 = 1'b0, last_1 = 1'b0;
    logic [DW-1:0] din_0 = '0, din_1 = '0;
    logic          ack_0, ack_1, sel, dout_valid, busy, owner;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout;

    beat_t         q0[$];
    beat_t         q1[$];
    logic [DW-1:0] exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc0 = 0, acc1 = 0, gate1_at = 0;
    int ack_cnt = 0, first_ack = -1, last_ack = -1, stall0 = 0;
    bit drv_on = 0, mon_on = 0;

    mux2_arbiter #(.data_size(DW), .max_burst(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .din_0(din_0), .last_0(last_0), .ack_0(ack_0),
        .req_1(req_1), .din_1(din_1), .last_1(last_1), .ack_1(ack_1),
        .sel(sel), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add0(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        q0.push_back(b);
    endtask

    task automatic add1(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        q1.push_back(b);
    endtask

    task automatic phase_reset();
        ack_cnt = 0; first_ack = -1; last_ack = -1; stall0 = 0;
        acc0 = 0; acc1 = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  n;
        bit  ok;
        n  = 0;
        ok = 0;
        while (!ok && n < budget) begin
            @(negedge clk); #1;
            n++;
            ok = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) &&
                 !busy && !dout_valid;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: not drained after %0d cycles, q0=%0d q1=%0d exp=%0d",
                     name, n, q0.size(), q1.size(), exp_q.size());
        end
    endtask

    // Requester model: retire a beat when it was acked, then present the next one.
    initial begin
        bit t0, t1;
        forever begin
            @(negedge clk);
            t0 = ack_0;
            t1 = ack_1;
            @(posedge clk); #1;
            if (drv_on) begin
                if (t0 && q0.size() > 0) begin void'(q0.pop_front()); acc0++; end
                if (t1 && q1.size() > 0) begin void'(q1.pop_front()); acc1++; end
                if (q0.size() > 0) begin
                    req_0 = 1'b1; din_0 = q0[0].data; last_0 = q0[0].last;
                end else begin
                    req_0 = 1'b0; last_0 = 1'b0;
                end
                if (q1.size() > 0 && acc0 >= gate1_at) begin
                    req_1 = 1'b1; din_1 = q1[0].data; last_1 = q1[0].last;
                end else begin
                    req_1 = 1'b0; last_1 = 1'b0;
                end
            end
        end
    end

    // Monitor: latency, sel/ack consistency, and scoreboard pop on consume.
    initial begin
        bit            pend;
        logic [DW-1:0] pend_d;
        logic [DW-1:0] e;
        pend = 0;
        pend_d = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (pend) begin
                    check("latency_valid", 64'(dout_valid), 64'd1);
                    check("latency_data", 64'(dout), 64'(pend_d));
                    pend = 0;
                end
                if (ack_0 || ack_1) begin
                    pend   = 1;
                    pend_d = ack_1 ? din_1 : din_0;
                    check("sel_vs_ack", 64'(sel), 64'(ack_1));
                    check("one_ack", 64'(ack_0 & ack_1), 64'd0);
                    ack_cnt++;
                    if (first_ack < 0) first_ack = cyc;
                    last_ack = cyc;
                end
                if (req_0 && !ack_0) stall0++;
                if (!busy) check("no_ack_idle", 64'({ack_0, ack_1}), 64'd0);
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra: got word %0h expected none", dout);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_word", 64'(dout), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit hit;

        // Reset held with random inputs: every output must stay zero.
        repeat (5) begin
            @(posedge clk); #1;
            req_0 = 1'($urandom_range(0, 1)); req_1 = 1'($urandom_range(0, 1));
            last_0 = 1'($urandom_range(0, 1)); last_1 = 1'($urandom_range(0, 1));
            din_0 = $urandom; din_1 = $urandom;
            dout_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_outputs", 64'({dout, dout_valid, sel, busy, owner, ack_0, ack_1}), 64'd0);
        end

        // Fairness: two 10-beat bursts, cap 4; also first grant after reset goes to 0.
        @(posedge clk); #1;
        req_0 = 0; req_1 = 0; last_0 = 0; last_1 = 0; din_0 = '0; din_1 = '0;
        dout_ready = 1;
        rst_n = 1;
        phase_reset();
        for (int i = 0; i < 10; i++) begin
            add0(32'h1000 + 32'(i), i == 9);
            add1(32'h2000 + 32'(i), i == 9);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h2000 + 32'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(32'h1000 + 32'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(32'h2000 + 32'(i));
        for (int i = 8; i < 10; i++) exp_q.push_back(32'h1000 + 32'(i));
        for (int i = 8; i < 10; i++) exp_q.push_back(32'h2000 + 32'(i));
        mon_on = 1;
        drv_on = 1;
        wait_done("fairness", 200);
        check("fair_acks", 64'(ack_cnt), 64'd20);
        check("fair_no_bubble", 64'(last_ack - first_ack + 1), 64'd20);
        check("fair_owner", 64'(owner), 64'd1);

        // Single 3-beat burst with one IDLE bubble before the first ack.
        phase_reset();
        add0(32'hA0, 0); add0(32'hA1, 0); add0(32'hA2, 1);
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1); exp_q.push_back(32'hA2);
        wait_done("single", 100);
        check("single_acks", 64'(ack_cnt), 64'd3);
        check("single_contig", 64'(last_ack - first_ack + 1), 64'd3);
        check("single_bubble", 64'(stall0), 64'd1);
        check("single_idle", 64'(busy), 64'd0);
        check("single_owner", 64'(owner), 64'd0);

        // Cap without contention: one 8-beat grant.
        phase_reset();
        for (int i = 0; i < 8; i++) begin
            add0(32'hC0 + 32'(i), i == 7);
            exp_q.push_back(32'hC0 + 32'(i));
        end
        wait_done("cap_solo", 100);
        check("cap_solo_acks", 64'(ack_cnt), 64'd8);
        check("cap_solo_contig", 64'(last_ack - first_ack + 1), 64'd8);
        check("cap_solo_bubble", 64'(stall0), 64'd1);

        // req_1 rises after beat 6: release after beat 7, GNT1, then back to 0.
        phase_reset();
        gate1_at = 6;
        for (int i = 0; i < 8; i++) add0(32'hD0 + 32'(i), i == 7);
        add1(32'hE0, 0); add1(32'hE1, 1);
        for (int i = 0; i < 7; i++) exp_q.push_back(32'hD0 + 32'(i));
        exp_q.push_back(32'hE0); exp_q.push_back(32'hE1); exp_q.push_back(32'hD7);
        wait_done("cap_late", 100);
        gate1_at = 0;
        check("cap_late_acks", 64'(ack_cnt), 64'd10);
        check("cap_late_contig", 64'(last_ack - first_ack + 1), 64'd10);
        check("cap_late_owner", 64'(owner), 64'd0);

        // Backpressure: consumer stalls 5 cycles while 0x55 is held.
        phase_reset();
        add0(32'h54, 0); add0(32'h55, 0); add0(32'h56, 0); add0(32'h57, 1);
        exp_q.push_back(32'h54); exp_q.push_back(32'h55);
        exp_q.push_back(32'h56); exp_q.push_back(32'h57);
        n = 0; hit = 0;
        while (!hit && n < 50) begin
            @(negedge clk); #1;
            n++;
            hit = ack_0 && (din_0 == 32'h55);
        end
        check("bp_found_55", 64'(hit), 64'd1);
        @(posedge clk); #1;
        dout_ready = 0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", 64'({ack_0, dout_valid, busy, sel}), 64'b0110);
            check("bp_dout", 64'(dout), 64'h55);
        end
        @(posedge clk); #1;
        dout_ready = 1;
        wait_done("backpressure", 100);
        check("bp_acks", 64'(ack_cnt), 64'd4);
        check("bp_span", 64'(last_ack - first_ack + 1), 64'd9);

        // Withdrawal: req_1 drops mid-burst, IDLE next cycle.
        phase_reset();
        add1(32'h70, 0); add1(32'h71, 0);
        exp_q.push_back(32'h70); exp_q.push_back(32'h71);
        n = 0;
        while (acc1 < 2 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("wd_reached", 64'(acc1), 64'd2);
        check("wd_busy_drop_cycle", 64'({busy, sel, req_1}), 64'b110);
        @(negedge clk); #1;
        check("wd_idle_next", 64'(busy), 64'd0);
        wait_done("withdraw", 50);

        // After withdrawal from GNT1 the priority points at requester 0.
        phase_reset();
        add0(32'h80, 1); add1(32'h90, 1);
        exp_q.push_back(32'h80); exp_q.push_back(32'h90);
        wait_done("prio_after_wd", 50);
        check("prio_owner", 64'(owner), 64'd1);

        // Reset during GNT1 with a held word: cleared immediately.
        phase_reset();
        dout_ready = 0;
        add1(32'hB0, 0); add1(32'hB1, 0); add1(32'hB2, 0);
        exp_q.push_back(32'hB0);
        n = 0; hit = 0;
        while (!hit && n < 50) begin
            @(negedge clk); #1;
            n++;
            hit = dout_valid && busy;
        end
        check("rst_mid_reached", 64'(hit), 64'd1);
        @(negedge clk); #2;
        check("rst_mid_before", 64'({sel, dout_valid, owner}), 64'b111);
        rst_n = 0;
        #1;
        check("rst_mid_after", 64'({dout_valid, sel, busy, owner, ack_1}), 64'd0);
        check("rst_mid_dout", 64'(dout), 64'd0);
        drv_on = 0;
        q1.delete();
        exp_q.delete();
        req_1 = 0; last_1 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        dout_ready = 1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 64'({busy, dout_valid, sel}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 2:1 datapath mux. Two requesters stream multi-beat bursts toward one consumer. The block owns the mux select line and registers the selected word into a single output stage with a valid/ready handshake. A burst-length cap prevents either requester from starving the other.

Parameters:
data_size, 32, width of each data word.
max_burst, 4, maximum beats per grant while the other requester is waiting (legal range 1..16).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_0  input  1  requester 0 has a beat available.
din_0  input  data_size  requester 0 data.
last_0  input  1  current req_0 beat ends its burst.
ack_0  output  1  requester 0 beat accepted this cycle (combinational).
req_1, din_1, last_1, ack_1  as above, for requester 1.
sel  output  1  mux select: 0 = din_0, 1 = din_1.
dout  output  data_size  registered output word.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout this cycle.
busy  output  1  a grant is active (state is not IDLE).
owner  output  1  requester that received the most recent grant.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, prio=0, beat_cnt=0.
  - dout=0, dout_valid=0, sel=0, busy=0, owner=0, ack_0=ack_1=0.
  - Reset mid-burst abandons the burst, and any held dout word is discarded.
- States: IDLE, GNT0, GNT1.
- Outputs decoded from state:
  - sel=1 only in GNT1; sel=0 in IDLE and GNT0.
  - busy = (state != IDLE).
- load_en = !dout_valid || dout_ready.
- Accept condition:
  - In GNTx, if req_x && load_en, then ack_x=1 and the beat transfers: dout<=din_x, dout_valid<=1, beat_cnt increments.
  - ack is never asserted in IDLE or for the non-owner.
- Output register:
  - When no beat transfers and dout_ready=1, dout_valid<=0.
  - dout holds its value until overwritten.
  - Latency: a beat accepted at edge N is visible on dout with dout_valid=1 after edge N. Throughput is 1 beat/clk while dout_ready=1.
- IDLE:
  - If only req_x is high, go to GNTx.
  - If both are high, go to GNT(prio).
  - On every grant, owner<=granted id and beat_cnt<=0.
  - One-cycle arbitration bubble: no ack is given in IDLE.
- GNTx release conditions, checked each cycle:
  - (a) A beat is accepted with last_x=1.
  - (b) A beat is accepted, beat_cnt+1 == max_burst, and req_y (the other requester) is high. This is a forced preemption; the requester resumes its burst on its next grant.
  - (c) req_x is low (requester withdrew).
- On release:
  - prio<=y.
  - If req_y is high, go directly to GNTy (owner<=y, beat_cnt<=0, no bubble).
  - Otherwise go to IDLE.
- A burst cap reached with req_y low does not release. beat_cnt saturates at max_burst. The cap re-applies as soon as req_y rises, with release on the next accepted beat.
- Backpressure: with dout_valid=1 and dout_ready=0, no ack is given, beat_cnt and state hold, and sel holds.
- Simultaneous load and consume (dout_ready=1 with a beat accepted): the new word replaces the old one and dout_valid stays 1.
- Requester contract: din_x and last_x are stable while req_x=1 and ack_x=0. The block does not check this.

Test Plan:
- Reset: hold rst_n=0, drive random inputs -> all outputs 0 and state IDLE. Deassert rst_n -> first grant goes to requester 0 when both request.
- Single burst: req_0 with 3 beats (0xA0, 0xA1, 0xA2 with last), dout_ready=1 -> ack_0 high for 3 consecutive cycles after a 1-cycle IDLE bubble. dout shows A0..A2 one cycle after each ack, then state returns to IDLE.
- Fairness: both requesters issue 10-beat bursts, max_burst=4 -> grant sequence 0(4),1(4),0(4),1(4),0(2),1(2). No bubble at switches. sel toggles exactly at state changes.
- Cap without contention: req_0 streams 8 beats with last on beat 8 and req_1 low -> a single grant of 8 beats. Raising req_1 after beat 6 -> release after beat 7, then GNT1.
- Backpressure: dout_ready=0 for 5 cycles mid-burst -> ack_0=0 and dout stable (0x55) throughout. Raising dout_ready -> transfer resumes at one beat/clk with no lost or duplicated words.
- Withdrawal and reset: req_1 drops mid-burst -> IDLE next cycle, prio=0. Asserting rst_n=0 during GNT1 with dout_valid=1 -> immediate dout_valid=0 and sel=0.
